staff_scroll_renderer: RTL and testbench
========================================

Name: staff_scroll_renderer

Overview:
- Parameterised successor to the staff overlay stage in the camera-clock video path. It draws a 5-line music staff plus scrolling noteheads for up to NUM_CHANNELS simultaneous MIDI notes.
- A beat timer derived from bpm snapshots received_note into a circular history, one column per beat: oldest column at left, newest at right.
- The output is a 2-bit pixel class consumed by the downstream pixel mixer.

Parameters:
- NUM_CHANNELS, 10, simultaneous note slots in received_note
- NOTE_W, 8, bits per note; value 0 means rest
- HISTORY_DEPTH, 16, beat columns shown; power of 2
- COL_W_LOG2, 5, column width = 2^COL_W_LOG2 px
- STAFF_LEFT, 64, x of first column
- STAFF_TOP, 100, y of top staff line
- LINE_SPACING, 8, px between staff lines; even
- BASE_NOTE, 64, note drawn on bottom line
- MAX_STEP, 12, highest drawable (note - BASE_NOTE)
- CLK_HZ, 200_000_000, clk_camera_in frequency
- H_ACTIVE, 1280, active width
- V_ACTIVE, 720, active height

Ports:
- clk_camera_in  in  1  sole clock
- rst_in  in  1  synchronous active-high reset
- hcount  in  11  pixel x
- vcount  in  10  pixel y
- bpm  in  8  tempo; 0 freezes scrolling
- received_note  in  NUM_CHANNELS*NOTE_W  current notes; channel i at bits [i*NOTE_W +: NOTE_W]
- staff_out  out  2  0 background, 1 staff line, 2 notehead, 3 cursor
- staff_valid  out  1  staff_out corresponds to an active pixel
- beat_tick  out  1  one-cycle pulse on each beat

Behaviour:
- Reset (rst_in=1 on a clock edge):
  - beat accumulator := 0, wr_ptr := 0, all history entries := 0 (rests).
  - Pixel pipeline is flushed: staff_out=0, staff_valid=0, beat_tick=0.
- Beat timer (decided tick rule: no divider, no overshoot carry):
  - acc width ceil(log2(60*CLK_HZ + 256)) bits. THRESH = 60*CLK_HZ.
  - Each cycle: if acc + bpm >= THRESH, then acc := acc + bpm - THRESH and beat_tick=1 that cycle. Otherwise acc := acc + bpm.
  - bpm=0: acc holds, no ticks. A bpm change takes effect the next cycle; acc is not cleared.
- History:
  - On beat_tick, hist[wr_ptr] := received_note and wr_ptr := wr_ptr+1, wrapping at HISTORY_DEPTH.
  - wr_ptr always indexes the oldest column.
- Pixel pipeline: fixed 3-cycle latency from hcount/vcount to staff_out/staff_valid.
  - S1: dx = hcount - STAFF_LEFT. in_staff = hcount in [STAFF_LEFT, STAFF_LEFT + HISTORY_DEPTH<<COL_W_LOG2). col = dx>>COL_W_LOG2, xoff = dx[COL_W_LOG2-1:0]. active = hcount<H_ACTIVE && vcount<V_ACTIVE.
  - S2: slot = (wr_ptr + col) mod HISTORY_DEPTH. Read hist[slot].
    - If a beat write and an S2 read hit the same slot in one cycle, the read returns the old contents.
  - S3: compute every channel in parallel.
    - step = note - BASE_NOTE. A note is drawable iff note != 0 and 0 <= step <= MAX_STEP.
    - y_n = STAFF_TOP + 4*LINE_SPACING - step*(LINE_SPACING/2).
    - Notehead hit iff drawable, |vcount - y_n| < LINE_SPACING/2, and xoff in [2, 2^COL_W_LOG2 - 3].
  - Staff line hit iff in_staff and vcount = STAFF_TOP + k*LINE_SPACING for some k in 0..4.
  - Priority: notehead(2) > cursor(3) > line(1) > 0. Pixels outside in_staff are 0.
  - staff_valid = active, delayed 3 cycles. staff_out is forced to 0 when not active.
- Duplicate notes across channels draw identically; no error is raised.
- Reset mid-frame: the next three outputs are 0/invalid and the history is blank.

Optional Feature:
- Macro: STAFF_CURSOR_EN.
- Defined: a 1-px vertical cursor (class 3) is drawn at xoff=0 of the newest column (col = HISTORY_DEPTH-1), vcount in [STAFF_TOP, STAFF_TOP + 4*LINE_SPACING].
- Undefined: class 3 is never produced, and cursor logic is absent.

Decomposition:
- Package staff_pkg holds:
  - enum pix_class_t {PIX_BG, PIX_LINE, PIX_NOTE, PIX_CURSOR}
  - constant NUM_STAFF_LINES=5
  - function note_y(step)
- One sub-module, staff_beat_timer: accumulator plus beat_tick, parameterised by CLK_HZ.

Test Plan:
- Beat timing (CLK_HZ=10, bpm=60): beat_tick every 10 cycles. bpm=0 → no ticks over 1000 cycles. bpm=120 → period 5.
- Latency: drive hcount=64, vcount=100 for one cycle after reset → staff_out=1 and staff_valid=1 exactly 3 cycles later. hcount=63 → staff_out=0.
- Note placement: received_note ch0=66, others 0, one tick. Newest column (col 15, x=544..575), vcount=124 (=132-8), xoff=10 → staff_out=2. vcount=119 → staff_out=0.
- Range limits: note 0, 63, or 77 → never class 2. Note 76 → y=84, drawn.
- Wrap: 17 ticks with notes 65..81 → oldest displayed is 66 at col 0, newest 81 (not drawable) at col 15. wr_ptr=1.
- Reset mid-frame plus cursor:
  - rst_in pulsed during active video → 3 invalid outputs, blank history.
  - With STAFF_CURSOR_EN, x=544, vcount=110 → 3. Without it → 1 on line rows, else 0.

Source files
------------

// File: rtl/staff_pkg.sv
// Shared pixel classes, staff geometry constants and the notehead y helper.
package staff_pkg;

  typedef enum logic [1:0] {
    PIX_BG     = 2'd0,
    PIX_LINE   = 2'd1,
    PIX_NOTE   = 2'd2,
    PIX_CURSOR = 2'd3
  } pix_class_t;

  localparam int unsigned NUM_STAFF_LINES = 5;

  // Centre row of a notehead; step 0 sits on the bottom line, each step is half a space up.
  function automatic int note_y(input int step, input int staff_top, input int line_spacing);
    return staff_top + (int'(NUM_STAFF_LINES) - 1) * line_spacing - step * (line_spacing / 2);
  endfunction

endpackage

// File: rtl/staff_beat_timer.sv
// Tempo accumulator: adds bpm every cycle and emits a one-cycle beat pulse
// each time 60*CLK_HZ is crossed; the remainder carries into the next beat.
module staff_beat_timer #(
  parameter int unsigned CLK_HZ = 200_000_000
) (
  input  logic       clk_camera_in,
  input  logic       rst_in,
  input  logic [7:0] bpm,
  output logic       beat_tick
);

  localparam longint unsigned THRESH = 64'(CLK_HZ) * 64'd60;
  localparam int unsigned     ACC_W  = $clog2(THRESH + 64'd256);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic             tick_q, tick_d;

  // acc stays below THRESH, so acc + 255 always fits in ACC_W bits
  always_comb begin
    sum    = acc_q + ACC_W'(bpm);
    acc_d  = sum;
    tick_d = 1'b0;
    if (sum >= ACC_W'(THRESH)) begin
      acc_d  = sum - ACC_W'(THRESH);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign beat_tick = tick_q;

endmodule

// File: rtl/staff_scroll_renderer.sv
// Music staff overlay with a scrolling per-beat note history, 3-cycle pixel pipeline.
// Optional 1-px newest-column cursor is built when STAFF_CURSOR_EN is defined.
module staff_scroll_renderer
  import staff_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 10,
  parameter int unsigned NOTE_W        = 8,
  parameter int unsigned HISTORY_DEPTH = 16,
  parameter int unsigned COL_W_LOG2    = 5,
  parameter int unsigned STAFF_LEFT    = 64,
  parameter int unsigned STAFF_TOP     = 100,
  parameter int unsigned LINE_SPACING  = 8,
  parameter int unsigned BASE_NOTE     = 64,
  parameter int unsigned MAX_STEP      = 12,
  parameter int unsigned CLK_HZ        = 200_000_000,
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned V_ACTIVE      = 720
) (
  input  logic                           clk_camera_in,
  input  logic                           rst_in,
  input  logic [10:0]                    hcount,
  input  logic [9:0]                     vcount,
  input  logic [7:0]                     bpm,
  input  logic [NUM_CHANNELS*NOTE_W-1:0] received_note,
  output logic [1:0]                     staff_out,
  output logic                           staff_valid,
  output logic                           beat_tick
);

  localparam int unsigned PTR_W   = $clog2(HISTORY_DEPTH);
  localparam int unsigned COL_W   = 1 << COL_W_LOG2;
  localparam int unsigned STAFF_W = HISTORY_DEPTH << COL_W_LOG2;
  localparam int unsigned HALF_SP = LINE_SPACING / 2;
  localparam int unsigned HIST_W  = NUM_CHANNELS * NOTE_W;

  staff_beat_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_beat_timer (
    .clk_camera_in(clk_camera_in),
    .rst_in       (rst_in),
    .bpm          (bpm),
    .beat_tick    (beat_tick)
  );

  // History ring: wr_ptr is both the next write slot and the oldest column
  logic [HIST_W-1:0] hist_q [HISTORY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(HISTORY_DEPTH); i++) hist_q[i] <= '0;
    end else if (beat_tick) begin
      hist_q[wr_ptr_q] <= received_note;
      wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
    end
  end

  // S1: column decode and active-area test
  logic [31:0]           dx;
  logic                  in_staff, active;
  logic [PTR_W-1:0]      s1_col_q;
  logic [COL_W_LOG2-1:0] s1_xoff_q;
  logic                  s1_in_staff_q, s1_active_q;
  logic [9:0]            s1_v_q;

  always_comb begin
    dx       = 32'(hcount) - 32'(STAFF_LEFT);
    in_staff = (32'(hcount) >= 32'(STAFF_LEFT)) && (32'(hcount) < 32'(STAFF_LEFT + STAFF_W));
    active   = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  end

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      s1_col_q      <= '0;
      s1_xoff_q     <= '0;
      s1_in_staff_q <= 1'b0;
      s1_active_q   <= 1'b0;
      s1_v_q        <= '0;
    end else begin
      s1_col_q      <= PTR_W'(dx >> COL_W_LOG2);
      s1_xoff_q     <= COL_W_LOG2'(dx);
      s1_in_staff_q <= in_staff;
      s1_active_q   <= active;
      s1_v_q        <= vcount;
    end
  end

  // S2: history read; a same-cycle beat write to this slot is not yet visible
  logic [HIST_W-1:0]     s2_notes_q;
  logic [COL_W_LOG2-1:0] s2_xoff_q;
  logic                  s2_in_staff_q, s2_active_q;
  logic [9:0]            s2_v_q;
`ifdef STAFF_CURSOR_EN
  logic                  s2_newest_q;
`endif

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      s2_notes_q    <= '0;
      s2_xoff_q     <= '0;
      s2_in_staff_q <= 1'b0;
      s2_active_q   <= 1'b0;
      s2_v_q        <= '0;
`ifdef STAFF_CURSOR_EN
      s2_newest_q   <= 1'b0;
`endif
    end else begin
      s2_notes_q    <= hist_q[wr_ptr_q + s1_col_q];
      s2_xoff_q     <= s1_xoff_q;
      s2_in_staff_q <= s1_in_staff_q;
      s2_active_q   <= s1_active_q;
      s2_v_q        <= s1_v_q;
`ifdef STAFF_CURSOR_EN
      s2_newest_q   <= (s1_col_q == PTR_W'(HISTORY_DEPTH - 1));
`endif
    end
  end

  // S3: per-channel notehead test, evaluated for all channels in parallel
  logic [NOTE_W-1:0] note;
  int                step, dy;
  logic              note_hit, line_hit, xoff_ok;

  always_comb begin
    note     = '0;
    step     = 0;
    dy       = 0;
    note_hit = 1'b0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      note = s2_notes_q[i*NOTE_W +: NOTE_W];
      step = int'(32'(note)) - int'(BASE_NOTE);
      dy   = int'(32'(s2_v_q)) - note_y(step, int'(STAFF_TOP), int'(LINE_SPACING));
      if ((note != '0) && (step >= 0) && (step <= int'(MAX_STEP)) &&
          (dy > -int'(HALF_SP)) && (dy < int'(HALF_SP)))
        note_hit = 1'b1;
    end
  end

  always_comb begin
    line_hit = 1'b0;
    for (int k = 0; k < int'(NUM_STAFF_LINES); k++) begin
      if (s2_v_q == 10'(int'(STAFF_TOP) + k * int'(LINE_SPACING))) line_hit = 1'b1;
    end
    xoff_ok = (s2_xoff_q >= COL_W_LOG2'(2)) && (s2_xoff_q <= COL_W_LOG2'(COL_W - 3));
  end

`ifdef STAFF_CURSOR_EN
  logic cursor_hit;
  always_comb begin
    cursor_hit = s2_newest_q && (s2_xoff_q == '0) &&
                 (s2_v_q >= 10'(STAFF_TOP)) &&
                 (s2_v_q <= 10'(STAFF_TOP + (NUM_STAFF_LINES - 1) * LINE_SPACING));
  end
`endif

  pix_class_t pix_d, pix_q;
  logic       valid_q;

  // Priority: notehead over cursor over staff line; nothing outside the staff or active area
  always_comb begin
    pix_d = PIX_BG;
    if (s2_active_q && s2_in_staff_q) begin
      if (note_hit && xoff_ok) pix_d = PIX_NOTE;
`ifdef STAFF_CURSOR_EN
      else if (cursor_hit)     pix_d = PIX_CURSOR;
`endif
      else if (line_hit)       pix_d = PIX_LINE;
    end
  end

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      pix_q   <= PIX_BG;
      valid_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      valid_q <= s2_active_q;
    end
  end

  assign staff_out   = pix_q;
  assign staff_valid = valid_q;

endmodule

// File: tb/tb_staff_scroll_renderer.sv
// Directed bench for staff_scroll_renderer (CLK_HZ=10 so beats are 10 cycles at 60 bpm).
module tb_staff_scroll_renderer;

  localparam int unsigned NCH = 10;
  localparam int unsigned NW  = 8;

`ifdef STAFF_CURSOR_EN
  localparam logic [1:0] CUR_MID  = 2'd3;
  localparam logic [1:0] CUR_LINE = 2'd3;
`else
  localparam logic [1:0] CUR_MID  = 2'd0;
  localparam logic [1:0] CUR_LINE = 2'd1;
`endif

  logic              clk;
  logic              rst;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic [7:0]        bpm;
  logic [NCH*NW-1:0] received_note;
  logic [1:0]        staff_out;
  logic              staff_valid;
  logic              beat_tick;

  int n_tests = 0;
  int n_fail  = 0;

  staff_scroll_renderer #(
    .CLK_HZ(10)
  ) dut (
    .clk_camera_in(clk),
    .rst_in       (rst),
    .hcount       (hcount),
    .vcount       (vcount),
    .bpm          (bpm),
    .received_note(received_note),
    .staff_out    (staff_out),
    .staff_valid  (staff_valid),
    .beat_tick    (beat_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [1:0]  exp_out;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Hold a pixel for the full pipeline depth, then compare class and valid
  task automatic pix(input string name, input int h, input int v, input int exp_out, input int exp_valid);
    hcount = 11'(h);
    vcount = 10'(v);
    repeat (3) step();
    check({name, "_out"}, int'(staff_out), exp_out);
    check({name, "_valid"}, int'(staff_valid), exp_valid);
  endtask

  // Returns cycles until the next beat pulse, or -1 if none within budget
  task automatic wait_tick(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (beat_tick) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Latch one history column: the write lands on the edge after the pulse
  task automatic write_notes(input logic [NCH*NW-1:0] notes);
    int c;
    received_note = notes;
    bpm = 8'd60;
    wait_tick(50, c);
    check("tick_seen", int'(c > 0), 1);
    step();
    bpm = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_out", int'(staff_out), 0);
    check("rst_valid", int'(staff_valid), 0);
    check("rst_tick", int'(beat_tick), 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [NCH*NW-1:0] n;
    int c, ticks;

    rst = 1'b1;
    hcount = '0;
    vcount = '0;
    bpm = '0;
    received_note = '0;
    do_reset();
    repeat (3) step();

    // Latency: a single-cycle staff-line pixel appears exactly three edges later
    hcount = 11'd64;
    vcount = 10'd100;
    step();
    hcount = 11'd0;
    vcount = 10'd0;
    step();
    check("lat_c2", int'(staff_out), 0);
    step();
    check("lat_c3_out", int'(staff_out), 1);
    check("lat_c3_valid", int'(staff_valid), 1);
    step();
    check("lat_c4", int'(staff_out), 0);
    pix("left_edge_63", 63, 100, 0, 1);

    // Beat timer periods
    bpm = 8'd60;
    wait_tick(100, c);
    wait_tick(100, c);
    check("period_60", c, 10);
    bpm = 8'd0;
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (beat_tick) ticks++;
    end
    check("bpm0_ticks", ticks, 0);
    bpm = 8'd120;
    wait_tick(100, c);
    wait_tick(100, c);
    check("period_120", c, 5);
    wait_tick(100, c);
    check("period_120b", c, 5);
    bpm = 8'd0;
    step();

    // One column: 66 twice (duplicate), plus 63 and 77 (undrawable) and 76 (top of range)
    n = '0;
    n[0*NW +: NW] = 8'd66;
    n[1*NW +: NW] = 8'd63;
    n[2*NW +: NW] = 8'd77;
    n[3*NW +: NW] = 8'd76;
    n[9*NW +: NW] = 8'd66;
    write_notes(n);

    vecs.push_back('{11'd64,   10'd100, 2'd1, 1'b1});
    vecs.push_back('{11'd63,   10'd100, 2'd0, 1'b1});
    vecs.push_back('{11'd575,  10'd132, 2'd1, 1'b1});
    vecs.push_back('{11'd576,  10'd132, 2'd0, 1'b1});
    vecs.push_back('{11'd300,  10'd101, 2'd0, 1'b1});
    vecs.push_back('{11'd300,  10'd133, 2'd0, 1'b1});
    vecs.push_back('{11'd554,  10'd124, 2'd2, 1'b1});
    vecs.push_back('{11'd554,  10'd119, 2'd0, 1'b1});
    vecs.push_back('{11'd554,  10'd121, 2'd2, 1'b1});
    vecs.push_back('{11'd554,  10'd127, 2'd2, 1'b1});
    vecs.push_back('{11'd554,  10'd128, 2'd0, 1'b1});
    vecs.push_back('{11'd545,  10'd124, 2'd1, 1'b1});
    vecs.push_back('{11'd546,  10'd124, 2'd2, 1'b1});
    vecs.push_back('{11'd573,  10'd124, 2'd2, 1'b1});
    vecs.push_back('{11'd574,  10'd124, 2'd1, 1'b1});
    vecs.push_back('{11'd554,  10'd84,  2'd2, 1'b1});
    vecs.push_back('{11'd554,  10'd80,  2'd0, 1'b1});
    vecs.push_back('{11'd554,  10'd136, 2'd0, 1'b1});
    vecs.push_back('{11'd522,  10'd124, 2'd1, 1'b1});
    vecs.push_back('{11'd1300, 10'd100, 2'd0, 1'b0});
    vecs.push_back('{11'd100,  10'd720, 2'd0, 1'b0});
    vecs.push_back('{11'd1279, 10'd719, 2'd0, 1'b1});
    vecs.push_back('{11'd544,  10'd110, CUR_MID,  1'b1});
    vecs.push_back('{11'd544,  10'd100, CUR_LINE, 1'b1});
    vecs.push_back('{11'd544,  10'd124, CUR_LINE, 1'b1});
    vecs.push_back('{11'd544,  10'd133, 2'd0, 1'b1});

    foreach (vecs[i]) begin
      pix($sformatf("vec%0d", i), int'(vecs[i].h), int'(vecs[i].v),
          int'(vecs[i].exp_out), int'(vecs[i].exp_valid));
    end

    // Wrap: 17 columns 65..81 leave 66 oldest at col 0 and 81 newest at col 15
    do_reset();
    for (int k = 0; k < 17; k++) begin
      n = '0;
      n[0*NW +: NW] = 8'(65 + k);
      write_notes(n);
    end
    check("wr_ptr", int'(dut.wr_ptr_q), 1);
    pix("wrap_col0_66", 74, 124, 2, 1);
    pix("wrap_col1_67", 106, 120, 2, 1);
    pix("wrap_col10_76", 394, 84, 2, 1);
    pix("wrap_col11_77", 426, 80, 0, 1);
    pix("wrap_col14_80", 522, 68, 0, 1);
    pix("wrap_col15_81", 554, 64, 0, 1);
    pix("wrap_col15_line", 554, 124, 1, 1);

    // Reset in the middle of active video
    hcount = 11'd74;
    vcount = 10'd124;
    repeat (3) step();
    check("pre_rst_out", int'(staff_out), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_v1", int'(staff_valid), 0);
    check("midrst_o1", int'(staff_out), 0);
    step();
    check("midrst_v2", int'(staff_valid), 0);
    step();
    check("midrst_v3", int'(staff_valid), 0);
    step();
    check("midrst_v4", int'(staff_valid), 1);
    check("midrst_blank", int'(staff_out), 1);
    pix("post_rst_cursor", 544, 110, int'(CUR_MID), 1);
    pix("post_rst_cursor_line", 544, 108, int'(CUR_LINE), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
